write_bus_regfile: RTL
======================

Name: write_bus_regfile

Overview:
- Bus C write-back block: the register bank that sources the read buses A/B.
- Captures the ALU result (cbus_in) into one destination register selected by cbus_en, and captures memory read data into ir or dstr.
- Performs the stand-alone pointer/counter updates: ac/mar increment, coun decrement.
- Drives every architectural register value continuously to the bus A/B muxes, plus a registered zero flag for coun-based loop control.

Parameters:
- WIDTH, 32, datapath and register width.
- COUN_INIT, 0, reset value of coun.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- cbus_en  in  4  destination select. 0 none, 1 sor, 2 dstr, 3 ac, 4 mar, 5 reg1, 6 reg2, 7 reg3, 8 coun, 9 ir, 10-15 illegal (no write).
- cbus_in  in  WIDTH  ALU result on bus C.
- mem_valid  in  1  memory read data valid this cycle.
- mem_dst  in  1  memory load target: 0 dstr, 1 ir.
- mem_data  in  WIDTH  memory read data.
- inc_ac  in  1  ac <= ac+1.
- inc_mar  in  1  mar <= mar+1.
- dec_coun  in  1  coun <= coun-1.
- ir, mar, sor, dstr, coun, ac, reg1, reg2, reg3  out  WIDTH each  register contents to bus A/B.
- z_coun  out  1  registered flag, 1 when coun == 0.
- wr_err  out  1  sticky flag, set on an illegal cbus_en code.

Behaviour:
- Reset (async, active-high, any time including mid-update): all registers 0 except coun = COUN_INIT; wr_err = 0; z_coun = (COUN_INIT == 0). Any in-flight update is discarded.
- All register updates occur on the rising clock edge; outputs reflect the new value the cycle after the write (1-cycle latency).
- No combinational path from inputs to outputs.
- Per-register next value, highest priority first:
  1. Memory load: mem_valid=1 and the register is the one selected by mem_dst → mem_data.
  2. Bus C write: cbus_en selects the register → cbus_in.
  3. Increment/decrement: inc_ac → ac+1; inc_mar → mar+1; dec_coun → coun-1.
  4. Otherwise hold.
- Independent targets update in the same cycle. Example: cbus_en=5 with inc_mar=1 writes reg1 and increments mar.
- Conflict resolution:
  - Same-target conflicts resolve by the priority above; the losing operation is dropped, not deferred.
  - Example: cbus_en=8 with dec_coun=1 loads cbus_in; no decrement.
  - Example: mem_valid, mem_dst=1, cbus_en=9 loads mem_data into ir.
- Arithmetic is modulo 2^WIDTH:
  - ac/mar at all-ones increment to 0.
  - coun at 0 decrements to all-ones; z_coun then deasserts.
- z_coun is registered from the next-state coun value, so it is valid in the same cycle coun shows the new value.
- wr_err:
  - Set on the clock edge when cbus_en is 10-15.
  - Cleared only by reset.
  - The illegal code writes nothing.
- cbus_en=0 with no other request: all registers hold.

Decomposition:
- Shared package bus_pkg holds:
  - WIDTH default.
  - cbus_en codes (CB_NONE, CB_SOR, CB_DSTR, CB_AC, CB_MAR, CB_REG1, CB_REG2, CB_REG3, CB_COUN, CB_IR).
  - mem_dst codes (MD_DSTR, MD_IR).
  - The bus A/B select codes, so all three bus blocks share one source.
- One sub-module: wb_reg. A WIDTH-bit register with async reset value, load_a (priority), load_b, and optional +1/-1 step. Instantiate it nine times.
- The cbus_en decoder and z_coun/wr_err logic stay in the top.

Test Plan:
- Reset then idle: after reset=1 for 2 cycles, then 0 with COUN_INIT=0 → all registers 0, z_coun=1, wr_err=0.
- Sweep writes: cbus_en=1..9 on consecutive cycles, cbus_in=32'h100+code → each register holds its value one cycle later; other registers unchanged.
- Conflict: cbus_en=8, cbus_in=5, dec_coun=1 → coun=5. Next cycle dec_coun=1 only → coun=4. Next: mem_valid=1, mem_dst=1, mem_data=32'hDEAD, cbus_en=9, cbus_in=1 → ir=32'hDEAD.
- Wrap: cbus_en=4, cbus_in=32'hFFFFFFFF, then inc_mar → mar=0. With coun=0, dec_coun → coun=32'hFFFFFFFF, z_coun 1→0. With coun=1, dec_coun → z_coun=1 in the same cycle coun reads 0.
- Illegal code: cbus_en=12, cbus_in=7 → no register changes; wr_err=1 and stays 1 through later legal writes until reset.
- Reset mid-operation: assert reset asynchronously between edges while inc_ac=1 and cbus_en=5 → outputs clear immediately without waiting for a clock edge; no update is applied on the following edge while reset is held.

Source files
------------

// File: rtl/bus_pkg.sv
// bus_pkg: shared widths and select codes for the bus A/B/C blocks.
package bus_pkg;
    localparam int BUS_WIDTH = 32;
    typedef enum logic [3:0] {
        CB_NONE, CB_SOR, CB_DSTR, CB_AC, CB_MAR, CB_REG1, CB_REG2, CB_REG3, CB_COUN, CB_IR
    } cbus_e;
    typedef enum logic {MD_DSTR, MD_IR} mem_dst_e;
    typedef enum logic [3:0] {
        BS_NONE, BS_IR, BS_MAR, BS_SOR, BS_DSTR, BS_COUN, BS_AC, BS_REG1, BS_REG2, BS_REG3
    } bus_sel_e;
endpackage

// File: rtl/wb_reg.sv
// wb_reg: one write-back register; load_a beats load_b beats the optional +1/-1 step.
module wb_reg #(
    parameter int           W       = 32,
    parameter logic [W-1:0] RST_VAL = '0,
    parameter int           STEP    = 0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load_a_i,
    input  logic [W-1:0] a_i,
    input  logic         load_b_i,
    input  logic [W-1:0] b_i,
    input  logic         step_i,
    output logic [W-1:0] q_o,
    output logic [W-1:0] d_o
);
    logic [W-1:0] q_q;
    always_comb d_o = load_a_i ? a_i : load_b_i ? b_i : !step_i ? q_q :
                      STEP > 0 ? q_q + W'(1) : STEP < 0 ? q_q - W'(1) : q_q;
    always_ff @(posedge clock or posedge reset)
        if (reset) q_q <= RST_VAL;
        else q_q <= d_o;
    assign q_o = q_q;
endmodule

// File: rtl/write_bus_regfile.sv
// write_bus_regfile: bus C write-back register bank feeding the bus A/B muxes.
module write_bus_regfile
    import bus_pkg::*;
#(
    parameter int               WIDTH     = BUS_WIDTH,
    parameter logic [WIDTH-1:0] COUN_INIT = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [3:0]       cbus_en,
    input  logic [WIDTH-1:0] cbus_in,
    input  logic             mem_valid,
    input  logic             mem_dst,
    input  logic [WIDTH-1:0] mem_data,
    input  logic             inc_ac,
    input  logic             inc_mar,
    input  logic             dec_coun,
    output logic [WIDTH-1:0] ir,
    output logic [WIDTH-1:0] mar,
    output logic [WIDTH-1:0] sor,
    output logic [WIDTH-1:0] dstr,
    output logic [WIDTH-1:0] coun,
    output logic [WIDTH-1:0] ac,
    output logic [WIDTH-1:0] reg1,
    output logic [WIDTH-1:0] reg2,
    output logic [WIDTH-1:0] reg3,
    output logic             z_coun,
    output logic             wr_err
);
    logic [WIDTH-1:0] r_q [1:9];
    logic [WIDTH-1:0] r_d [1:9];
    logic             z_coun_q, wr_err_q;
    // Array slot n holds the register whose cbus_en code is n.
    for (genvar g = 1; g <= 9; g++) begin : g_reg
        localparam logic [3:0] C = 4'(g);
        wb_reg #(
            .W       (WIDTH),
            .RST_VAL (C == CB_COUN ? COUN_INIT : '0),
            .STEP    (C == CB_AC || C == CB_MAR ? 1 : C == CB_COUN ? -1 : 0)
        ) u_reg (
            .clock    (clock),
            .reset    (reset),
            .load_a_i (mem_valid && ((C == CB_DSTR && mem_dst == MD_DSTR) || (C == CB_IR && mem_dst == MD_IR))),
            .a_i      (mem_data),
            .load_b_i (cbus_en == C),
            .b_i      (cbus_in),
            .step_i   (C == CB_AC ? inc_ac : C == CB_MAR ? inc_mar : C == CB_COUN ? dec_coun : 1'b0),
            .q_o      (r_q[g]),
            .d_o      (r_d[g])
        );
    end
    // z_coun tracks the next coun value so it lines up with coun itself.
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            z_coun_q <= COUN_INIT == '0;
            wr_err_q <= 1'b0;
        end else begin
            z_coun_q <= r_d[CB_COUN] == '0;
            wr_err_q <= wr_err_q | (cbus_en > CB_IR);
        end
    assign sor    = r_q[CB_SOR];
    assign dstr   = r_q[CB_DSTR];
    assign ac     = r_q[CB_AC];
    assign mar    = r_q[CB_MAR];
    assign reg1   = r_q[CB_REG1];
    assign reg2   = r_q[CB_REG2];
    assign reg3   = r_q[CB_REG3];
    assign coun   = r_q[CB_COUN];
    assign ir     = r_q[CB_IR];
    assign z_coun = z_coun_q;
    assign wr_err = wr_err_q;
endmodule
